// File: rtl/pcie_128b130b_pkg.sv
// Shared constants and types for the 128b/130b encoder, decoder and scrambler.
package pcie_128b130b_pkg;

    localparam int LFSR_W = 23;
    localparam int PAYLOAD_W = 128;

    localparam logic [1:0] SH_DATA  = 2'b01;
    localparam logic [1:0] SH_CTL   = 2'b10;
    localparam logic [7:0] EIEOS_ID = 8'h00;

    // Low-order terms of G(X)=X^23+X^21+X^16+X^8+X^5+X^2+1
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 23'h210125;

    typedef logic [129:0] enc_block_t;

endpackage

// File: rtl/pcie_gen3_scrambler128.sv
// Combinational 128-bit keystream and next LFSR state for the Gen3 Galois scrambler.
module pcie_gen3_scrambler128
    import pcie_128b130b_pkg::*;
(
    input  logic [LFSR_W-1:0]    lfsr,
    output logic [PAYLOAD_W-1:0] keystream,
    output logic [LFSR_W-1:0]    lfsr_next
);

    logic [LFSR_W-1:0] state;

    always_comb begin
        state     = lfsr;
        keystream = '0;
        for (int i = 0; i < PAYLOAD_W; i++) begin
            keystream[i] = state[LFSR_W-1];
            state = {state[LFSR_W-2:0], 1'b0} ^ (state[LFSR_W-1] ? LFSR_TAPS : '0);
        end
        lfsr_next = state;
    end

endmodule

// File: rtl/pcie_128b130b_encoder.sv
// 128b/130b TX block encoder with a 2-entry registered output queue.
// Scrambling is built only when PCIE_ENC_SCRAMBLE_EN is defined.
module pcie_128b130b_encoder
    import pcie_128b130b_pkg::*;
#(
    parameter logic [22:0] LFSR_SEED = 23'h1DBFBC,
    parameter int          CNT_W     = 32
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [127:0]         in_data,
    input  logic                 in_is_ctl,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [129:0]         out_block,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CNT_W-1:0]     data_blk_cnt,
    output logic [CNT_W-1:0]     ctl_blk_cnt
);

    enc_block_t     q0;
    enc_block_t     q1;
    enc_block_t     new_blk;
    logic [1:0]     count;
    logic           push;
    logic           pop;
    logic [127:0]   ks;

    assign pop       = (count != 2'd0) & out_ready;
    assign in_ready  = (count < 2'd2) | pop;
    assign push      = in_valid & in_ready;
    assign out_valid = (count != 2'd0);
    assign out_block = q0;

`ifdef PCIE_ENC_SCRAMBLE_EN
    logic [LFSR_W-1:0] lfsr;
    logic [LFSR_W-1:0] lfsr_next;
    logic              is_eieos;

    pcie_gen3_scrambler128 u_scrambler (
        .lfsr      (lfsr),
        .keystream (ks),
        .lfsr_next (lfsr_next)
    );

    assign is_eieos = in_is_ctl & (in_data[7:0] == EIEOS_ID);

    // Only accepted data blocks consume keystream; EIEOS restarts the sequence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= LFSR_SEED;
        end else if (push) begin
            if (!in_is_ctl) begin
                lfsr <= lfsr_next;
            end else if (is_eieos) begin
                lfsr <= LFSR_SEED;
            end
        end
    end
`else
    logic unused_seed;

    assign ks          = '0;
    assign unused_seed = ^LFSR_SEED;
`endif

    assign new_blk = in_is_ctl ? {SH_CTL, in_data} : {SH_DATA, in_data ^ ks};

    // q0 is always the head; q1 only holds a block while count==2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q0    <= '0;
            q1    <= '0;
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        q0 <= new_blk;
                    end else begin
                        q1 <= new_blk;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    q0    <= q1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        q0 <= new_blk;
                    end else begin
                        q0 <= q1;
                        q1 <= new_blk;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_blk_cnt <= '0;
            ctl_blk_cnt  <= '0;
        end else if (push) begin
            if (in_is_ctl) begin
                ctl_blk_cnt <= ctl_blk_cnt + CNT_W'(1);
            end else begin
                data_blk_cnt <= data_blk_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pcie_128b130b_encoder.sv
// Self-checking bench for pcie_128b130b_encoder against a polynomial-arithmetic reference model.
module tb_pcie_128b130b_encoder;

`ifdef PCIE_ENC_SCRAMBLE_EN
    localparam bit SCR = 1'b1;
`else
    localparam bit SCR = 1'b0;
`endif
    localparam logic [22:0] SEED = 23'h1DBFBC;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] in_data;
    logic         in_is_ctl;
    logic         in_valid;
    logic         in_ready;
    logic [129:0] out_block;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  data_blk_cnt;
    logic [31:0]  ctl_blk_cnt;

    int           n_tests = 0;
    int           n_fail = 0;
    logic [22:0]  m_lfsr;
    int unsigned  m_dcnt;
    int unsigned  m_ccnt;
    logic [129:0] exp_q[$];

    pcie_128b130b_encoder #(.LFSR_SEED(SEED), .CNT_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_is_ctl    (in_is_ctl),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_block    (out_block),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .data_blk_cnt (data_blk_cnt),
        .ctl_blk_cnt  (ctl_blk_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before 200000");
        $fatal(1);
    end

    // Keystream as successive multiplication of the state polynomial by X modulo G(X).
    function automatic logic [127:0] model_ks(input logic [22:0] seed, output logic [22:0] after);
        logic [23:0]  p;
        logic [127:0] ks;
        p = {1'b0, seed};
        for (int i = 0; i < 128; i++) begin
            p = p << 1;
            ks[i] = p[23];
            if (p[23]) p = p ^ 24'hA10125;
        end
        after = p[22:0];
        return ks;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic m_reset();
        m_lfsr = SEED;
        m_dcnt = 0;
        m_ccnt = 0;
        exp_q.delete();
    endtask

    task automatic m_accept(input logic [127:0] d, input bit ctl, output logic [129:0] blk);
        logic [127:0] ks;
        logic [22:0]  nx;
        if (!ctl) begin
            ks = model_ks(m_lfsr, nx);
            if (SCR) begin
                blk = {2'b01, d ^ ks};
                m_lfsr = nx;
            end else begin
                blk = {2'b01, d};
            end
            m_dcnt++;
        end else begin
            blk = {2'b10, d};
            if (SCR && d[7:0] == 8'h00) m_lfsr = SEED;
            m_ccnt++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_is_ctl = 1'b0; in_data = '0; out_ready = 1'b0;
        m_reset();
        #3;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_tests++; if (out_block !== 130'd0) begin n_fail++; $display("FAIL reset_out_block: got %h want 0", out_block); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_tests++; if (data_blk_cnt !== 32'd0 || ctl_blk_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_counters: got %0d/%0d want 0/0", data_blk_cnt, ctl_blk_cnt); end
        @(posedge clk); #3; rst = 1'b0;
        tick();
    endtask

    task automatic test_control();
        logic [127:0] d;
        logic [129:0] e;
        d = rand128(); d[15:0] = 16'hA500;
        out_ready = 1'b1; in_valid = 1'b1; in_is_ctl = 1'b1; in_data = d;
        m_accept(d, 1'b1, e);
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ctl_in_ready: got %b want 1", in_ready); end
        tick(); in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ctl_out_valid: got %b want 1", out_valid); end
        n_tests++; if (out_block !== e) begin n_fail++; $display("FAIL ctl_out_block: got %h want %h", out_block, e); end
        n_tests++; if (ctl_blk_cnt !== m_ccnt || data_blk_cnt !== m_dcnt) begin n_fail++; $display("FAIL ctl_counters: got %0d/%0d want %0d/%0d", ctl_blk_cnt, data_blk_cnt, m_ccnt, m_dcnt); end
        tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ctl_drained: got %b want 0", out_valid); end
    endtask

    task automatic test_data_seed();
        logic [129:0] e;
        logic [127:0] gk;
        logic [22:0]  nx;
        gk = model_ks(23'h1DBFBC, nx);
        out_ready = 1'b1; in_valid = 1'b1; in_is_ctl = 1'b0; in_data = '0;
        m_accept(128'd0, 1'b0, e);
        tick(); in_valid = 1'b0;
        n_tests++; if (out_block[129:128] !== 2'b01) begin n_fail++; $display("FAIL seed_sync_hdr: got %b want 01", out_block[129:128]); end
        n_tests++; if (out_block[127:0] !== (SCR ? gk : 128'd0)) begin n_fail++; $display("FAIL seed_keystream: got %h want %h", out_block[127:0], SCR ? gk : 128'd0); end
        n_tests++; if (out_block !== e) begin n_fail++; $display("FAIL seed_block: got %h want %h", out_block, e); end
        n_tests++; if (data_blk_cnt !== 32'd1) begin n_fail++; $display("FAIL seed_data_cnt: got %0d want 1", data_blk_cnt); end
        tick();
    endtask

    task automatic test_eieos_reseed();
        logic [127:0] d[5];
        bit           c[5];
        logic [129:0] e;
        logic [129:0] got[5];
        d[0] = rand128(); d[0][7:0] = 8'h00; c[0] = 1'b1;
        d[1] = '0;                            c[1] = 1'b0;
        d[2] = rand128();                     c[2] = 1'b0;
        d[3] = rand128(); d[3][7:0] = 8'h00; c[3] = 1'b1;
        d[4] = '0;                            c[4] = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_is_ctl = c[i]; in_data = d[i];
            m_accept(d[i], c[i], e);
            tick();
            got[i] = out_block;
            n_tests++; if (out_block !== e) begin n_fail++; $display("FAIL reseed_block%0d: got %h want %h", i, out_block, e); end
        end
        in_valid = 1'b0;
        n_tests++; if (got[4][127:0] !== got[1][127:0]) begin n_fail++; $display("FAIL reseed_repeat: got %h want %h", got[4][127:0], got[1][127:0]); end
        tick();
    endtask

    task automatic test_backpressure();
        logic [127:0] d[3];
        logic [129:0] e[3];
        logic [31:0]  cnt_before;
        for (int i = 0; i < 3; i++) d[i] = rand128();
        out_ready = 1'b0; in_is_ctl = 1'b0;
        in_valid = 1'b1; in_data = d[0]; m_accept(d[0], 1'b0, e[0]); tick();
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after1: got %b want 1", in_ready); end
        in_data = d[1]; m_accept(d[1], 1'b0, e[1]); tick();
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_after2: got %b want 0", in_ready); end
        cnt_before = data_blk_cnt;
        in_data = d[2];
        tick(); tick();
        n_tests++; if (out_block !== e[0] || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_head_hold: got %h want %h", out_block, e[0]); end
        n_tests++; if (data_blk_cnt !== cnt_before) begin n_fail++; $display("FAIL bp_no_transfer: got %0d want %0d", data_blk_cnt, cnt_before); end
        out_ready = 1'b1; #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_on_pop: got %b want 1", in_ready); end
        m_accept(d[2], 1'b0, e[2]);
        @(posedge clk); #1; in_valid = 1'b0;
        n_tests++; if (out_block !== e[1]) begin n_fail++; $display("FAIL bp_out2: got %h want %h", out_block, e[1]); end
        tick();
        n_tests++; if (out_block !== e[2] || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out3: got %h want %h", out_block, e[2]); end
        tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got %b want 0", out_valid); end
    endtask

    task automatic test_full_push_pop();
        logic [127:0] d[3];
        logic [129:0] e[3];
        for (int i = 0; i < 3; i++) d[i] = rand128();
        d[2][7:0] = d[2][7:0] | 8'h01;
        out_ready = 1'b0; in_is_ctl = 1'b0; in_valid = 1'b1;
        in_data = d[0]; m_accept(d[0], 1'b0, e[0]); tick();
        in_data = d[1]; m_accept(d[1], 1'b0, e[1]); tick();
        out_ready = 1'b1; in_is_ctl = 1'b1; in_data = d[2]; #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready: got %b want 1", in_ready); end
        m_accept(d[2], 1'b1, e[2]);
        @(posedge clk); #1; in_valid = 1'b0; out_ready = 1'b0; #1;
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_count_stays2: got ready %b want 0", in_ready); end
        n_tests++; if (out_block !== e[1]) begin n_fail++; $display("FAIL full_head: got %h want %h", out_block, e[1]); end
        out_ready = 1'b1;
        tick();
        n_tests++; if (out_block !== e[2] || out_valid !== 1'b1) begin n_fail++; $display("FAIL full_tail: got %h want %h", out_block, e[2]); end
        tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL full_drained: got %b want 0", out_valid); end
    endtask

    task automatic test_reset_midstream();
        logic [127:0] d;
        logic [129:0] e;
        logic [127:0] gk;
        logic [22:0]  nx;
        out_ready = 1'b0; in_is_ctl = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            d = rand128(); in_data = d; m_accept(d, 1'b0, e); tick();
        end
        in_valid = 1'b0;
        #2; rst = 1'b1; #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
        n_tests++; if (out_block !== 130'd0) begin n_fail++; $display("FAIL mid_out_block: got %h want 0", out_block); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_in_ready: got %b want 1", in_ready); end
        n_tests++; if (data_blk_cnt !== 32'd0 || ctl_blk_cnt !== 32'd0) begin n_fail++; $display("FAIL mid_counters: got %0d/%0d want 0/0", data_blk_cnt, ctl_blk_cnt); end
        m_reset();
        #3; rst = 1'b0;
        tick();
        d = rand128(); gk = model_ks(23'h1DBFBC, nx);
        out_ready = 1'b1; in_valid = 1'b1; in_is_ctl = 1'b0; in_data = d;
        m_accept(d, 1'b0, e);
        tick(); in_valid = 1'b0;
        n_tests++; if (out_block !== {2'b01, d ^ (SCR ? gk : 128'd0)}) begin n_fail++; $display("FAIL mid_first_data: got %h want %h", out_block, {2'b01, d ^ (SCR ? gk : 128'd0)}); end
        n_tests++; if (out_block !== e) begin n_fail++; $display("FAIL mid_model: got %h want %h", out_block, e); end
        tick();
    endtask

    task automatic test_random();
        bit           pend = 1'b0;
        bit           exp_ready;
        bit           do_pop;
        logic [129:0] e;
        for (int i = 0; i < 400; i++) begin
            if (!pend) begin
                in_valid  = ($urandom % 4) != 0;
                in_data   = rand128();
                if ($urandom % 6 == 0) in_data[7:0] = 8'h00;
                in_is_ctl = ($urandom % 3) == 0;
            end
            out_ready = ($urandom % 3) != 0;
            #1;
            do_pop    = (exp_q.size() != 0) && out_ready;
            exp_ready = (exp_q.size() < 2) || do_pop;
            n_tests++; if (in_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_in_ready@%0d: got %b want %b", i, in_ready, exp_ready); end
            n_tests++; if (out_valid !== (exp_q.size() != 0)) begin n_fail++; $display("FAIL rnd_out_valid@%0d: got %b want %b", i, out_valid, exp_q.size() != 0); end
            if (do_pop) begin
                n_tests++; if (out_block !== exp_q[0]) begin n_fail++; $display("FAIL rnd_out_block@%0d: got %h want %h", i, out_block, exp_q[0]); end
                void'(exp_q.pop_front());
            end
            if (in_valid && exp_ready) begin
                m_accept(in_data, in_is_ctl, e);
                exp_q.push_back(e);
                pend = 1'b0;
            end else begin
                pend = in_valid;
            end
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (exp_q.size() != 0) begin
                n_tests++; if (out_block !== exp_q[0] || out_valid !== 1'b1) begin n_fail++; $display("FAIL rnd_drain%0d: got %h want %h", i, out_block, exp_q[0]); end
                void'(exp_q.pop_front());
            end
            tick();
        end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_empty: got %b want 0", out_valid); end
        n_tests++; if (data_blk_cnt !== m_dcnt || ctl_blk_cnt !== m_ccnt) begin n_fail++; $display("FAIL rnd_counters: got %0d/%0d want %0d/%0d", data_blk_cnt, ctl_blk_cnt, m_dcnt, m_ccnt); end
    endtask

    initial begin
        test_reset();
        test_control();
        test_data_seed();
        test_eieos_reseed();
        test_backpressure();
        test_full_push_pop();
        test_reset_midstream();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
